e203_exu_fpu_fmis_mv_pipe: RTL and testbench

Parametrised single-precision FPU miscellaneous-move unit for the E203 EXU FPU path. It covers FMV.X.W, FMV.W.X, FSGNJ/FSGNJN/FSGNJX and optionally FCLASS, with NaN-boxing for FLEN=64. Results pass through a registered output buffer of configurable depth, so input and output handshakes are decoupled. It replaces the combinational move path feeding the FPU writeback arbiter.

---
 rtl/e203_exu_fpu_fmis_mv_pipe_pkg.sv | 72 +++++++
 rtl/e203_exu_fpu_fmis_obuf.sv | 80 ++++++++
 rtl/e203_exu_fpu_fmis_mv_pipe.sv | 94 +++++++++
 tb/tb_e203_exu_fpu_fmis_mv_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/e203_exu_fpu_fmis_mv_pipe_pkg.sv
// Shared definitions for the FPU miscellaneous-move unit: op encodings,
// canonical NaN, FCLASS bit positions and the NaN-box helpers.
package e203_fpu_fmis_pkg;

  typedef enum logic [2:0] {
    FMIS_OP_FMV_X_W = 3'd0,
    FMIS_OP_FMV_W_X = 3'd1,
    FMIS_OP_FSGNJ   = 3'd2,
    FMIS_OP_FSGNJN  = 3'd3,
    FMIS_OP_FSGNJX  = 3'd4,
    FMIS_OP_FCLASS  = 3'd5
  } fmis_op_e;

  localparam logic [31:0] FMIS_CANON_NAN = 32'h7FC0_0000;

  // FCLASS result bit positions (RISC-V order)
  localparam int unsigned FMIS_CLS_NEG_INF  = 0;
  localparam int unsigned FMIS_CLS_NEG_NORM = 1;
  localparam int unsigned FMIS_CLS_NEG_SUB  = 2;
  localparam int unsigned FMIS_CLS_NEG_ZERO = 3;
  localparam int unsigned FMIS_CLS_POS_ZERO = 4;
  localparam int unsigned FMIS_CLS_POS_SUB  = 5;
  localparam int unsigned FMIS_CLS_POS_NORM = 6;
  localparam int unsigned FMIS_CLS_POS_INF  = 7;
  localparam int unsigned FMIS_CLS_SNAN     = 8;
  localparam int unsigned FMIS_CLS_QNAN     = 9;

  // Single-precision view of an FP register: a badly boxed value reads as canonical NaN.
  function automatic logic [31:0] fmis_unbox(input logic upper_ones, input logic [31:0] lo);
    if (upper_ones) begin
      return lo;
    end else begin
      return FMIS_CANON_NAN;
    end
  endfunction

  // NaN-box a single-precision value into a 64-bit register image.
  function automatic logic [63:0] fmis_nanbox64(input logic [31:0] v);
    return {32'hFFFF_FFFF, v};
  endfunction

  // One-hot classification of a single-precision value.
  function automatic logic [9:0] fmis_fclass(input logic [31:0] v);
    logic       sgn;
    logic [7:0] expo;
    logic [22:0] frac;
    logic [9:0] mask;
    sgn  = v[31];
    expo = v[30:23];
    frac = v[22:0];
    mask = 10'd0;
    if (expo == 8'hFF) begin
      if (frac == 23'd0) begin
        mask[sgn ? FMIS_CLS_NEG_INF : FMIS_CLS_POS_INF] = 1'b1;
      end else if (frac[22]) begin
        mask[FMIS_CLS_QNAN] = 1'b1;
      end else begin
        mask[FMIS_CLS_SNAN] = 1'b1;
      end
    end else if (expo == 8'h00) begin
      if (frac == 23'd0) begin
        mask[sgn ? FMIS_CLS_NEG_ZERO : FMIS_CLS_POS_ZERO] = 1'b1;
      end else begin
        mask[sgn ? FMIS_CLS_NEG_SUB : FMIS_CLS_POS_SUB] = 1'b1;
      end
    end else begin
      mask[sgn ? FMIS_CLS_NEG_NORM : FMIS_CLS_POS_NORM] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/e203_exu_fpu_fmis_obuf.sv
// Registered output FIFO with synchronous flush. Input ready never depends
// on the read side in the same cycle, so a full buffer takes a bubble.
module e203_exu_fpu_fmis_obuf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_valid,
  input  logic             i_rd_ready,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign o_ready = (r_cnt != CNT_FULL) & ~i_flush;
  assign o_valid = (r_cnt != '0);
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_rd_ready;

  // Pointer and occupancy bookkeeping; flush empties the buffer next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Entry storage; cleared on reset so an empty buffer presents zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/e203_exu_fpu_fmis_mv_pipe.sv
// FPU miscellaneous moves (FMV.X.W, FMV.W.X, FSGNJ*, optional FCLASS) with a
// registered output buffer. FCLASS is built only when E203_FPU_FCLASS_EN is
// defined; otherwise op 5 reports as illegal.
module e203_exu_fpu_fmis_mv_pipe
  import e203_fpu_fmis_pkg::*;
#(
  parameter int unsigned FLEN       = 32,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ITAG_W     = 3,
  parameter int unsigned OBUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fmis_flush,
  input  logic              fmis_mv_i_valid,
  output logic              fmis_mv_i_ready,
  input  logic [2:0]        fmis_i_op,
  input  logic [FLEN-1:0]   fmis_i_rs1,
  input  logic [FLEN-1:0]   fmis_i_rs2,
  input  logic [ITAG_W-1:0] fmis_i_itag,
  output logic              fmis_mv_o_valid,
  input  logic              fmis_mv_o_ready,
  output logic [FLEN-1:0]   fmis_mv_o_wbck_wdat,
  output logic              fmis_mv_o_wbck_int,
  output logic [ITAG_W-1:0] fmis_mv_o_itag,
  output logic              fmis_mv_o_err
);

  localparam int unsigned ENT_W = FLEN + ITAG_W + 2;

  logic              w_rs1_boxed;
  logic              w_rs2_boxed;
  logic [31:0]       w_a;
  logic [31:0]       w_b;
  logic [FLEN-1:0]   w_wdat;
  logic              w_int;
  logic              w_err;
  logic [ENT_W-1:0]  w_ent_in;
  logic [ENT_W-1:0]  w_ent_out;

  // Upper half all ones means a properly boxed single; always true at FLEN=32.
  assign w_rs1_boxed = &(fmis_i_rs1 | FLEN'(32'hFFFF_FFFF));
  assign w_rs2_boxed = &(fmis_i_rs2 | FLEN'(32'hFFFF_FFFF));
  assign w_a = fmis_unbox(w_rs1_boxed, fmis_i_rs1[31:0]);
  assign w_b = fmis_unbox(w_rs2_boxed, fmis_i_rs2[31:0]);

  // Result datapath: select per op, NaN-box FP results, flag illegal ops.
  always_comb begin
    w_wdat = '0;
    w_int  = 1'b0;
    w_err  = 1'b0;
    case (fmis_i_op)
      FMIS_OP_FMV_X_W: begin
        w_wdat = FLEN'(fmis_i_rs1[31:0]);
        w_int  = 1'b1;
      end
      FMIS_OP_FMV_W_X: w_wdat = FLEN'(fmis_nanbox64(fmis_i_rs1[31:0]));
      FMIS_OP_FSGNJ:   w_wdat = FLEN'(fmis_nanbox64({w_b[31], w_a[30:0]}));
      FMIS_OP_FSGNJN:  w_wdat = FLEN'(fmis_nanbox64({~w_b[31], w_a[30:0]}));
      FMIS_OP_FSGNJX:  w_wdat = FLEN'(fmis_nanbox64({w_a[31] ^ w_b[31], w_a[30:0]}));
`ifdef E203_FPU_FCLASS_EN
      FMIS_OP_FCLASS: begin
        w_wdat = FLEN'(fmis_fclass(w_a));
        w_int  = 1'b1;
      end
`endif
      default: begin
        w_wdat = '0;
        w_int  = 1'b0;
        w_err  = 1'b1;
      end
    endcase
  end

  assign w_ent_in = {w_wdat, w_int, fmis_i_itag, w_err};

  e203_exu_fpu_fmis_obuf #(
    .WIDTH (ENT_W),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (fmis_flush),
    .i_valid    (fmis_mv_i_valid),
    .o_ready    (fmis_mv_i_ready),
    .i_wdata    (w_ent_in),
    .o_valid    (fmis_mv_o_valid),
    .i_rd_ready (fmis_mv_o_ready),
    .o_rdata    (w_ent_out)
  );

  assign {fmis_mv_o_wbck_wdat, fmis_mv_o_wbck_int, fmis_mv_o_itag, fmis_mv_o_err} = w_ent_out;

endmodule

// File: tb/tb_e203_exu_fpu_fmis_mv_pipe.sv
// Self-checking bench: FLEN=64, OBUF_DEPTH=2. Directed test-plan cases,
// backpressure, flush and async reset, then randomized traffic against a
// queue-based reference model.
module tb_e203_exu_fpu_fmis_mv_pipe;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        i_valid;
  logic        i_ready;
  logic [2:0]  op;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [2:0]  itag;
  logic        o_valid;
  logic        o_ready;
  logic [63:0] wdat;
  logic        wint;
  logic [2:0]  o_itag;
  logic        err;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [63:0] wd;
    logic        intf;
    logic [2:0]  tag;
    logic        err;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  e203_exu_fpu_fmis_mv_pipe #(
    .FLEN(64), .XLEN(32), .ITAG_W(3), .OBUF_DEPTH(DEPTH)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fmis_flush          (flush),
    .fmis_mv_i_valid     (i_valid),
    .fmis_mv_i_ready     (i_ready),
    .fmis_i_op           (op),
    .fmis_i_rs1          (rs1),
    .fmis_i_rs2          (rs2),
    .fmis_i_itag         (itag),
    .fmis_mv_o_valid     (o_valid),
    .fmis_mv_o_ready     (o_ready),
    .fmis_mv_o_wbck_wdat (wdat),
    .fmis_mv_o_wbck_int  (wint),
    .fmis_mv_o_itag      (o_itag),
    .fmis_mv_o_err       (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] fclass_ref(input logic [31:0] v);
    int idx;
    logic neg;
    int e;
    int f;
    neg = v[31];
    e = int'(v[30:23]);
    f = int'(v[22:0]);
    if (e == 255)      idx = (f == 0) ? (neg ? 0 : 7) : ((f >= 32'h40_0000) ? 9 : 8);
    else if (e == 0)   idx = (f == 0) ? (neg ? 3 : 4) : (neg ? 2 : 5);
    else               idx = neg ? 1 : 6;
    return 64'd1 << idx;
  endfunction

  function automatic ent_t ref_model(input logic [2:0] o, input logic [63:0] r1,
                                     input logic [63:0] r2, input logic [2:0] t);
    ent_t e;
    logic [31:0] a;
    logic [31:0] b;
    a = (r1[63:32] == 32'hFFFF_FFFF) ? r1[31:0] : 32'h7FC0_0000;
    b = (r2[63:32] == 32'hFFFF_FFFF) ? r2[31:0] : 32'h7FC0_0000;
    e.wd = 64'd0; e.intf = 1'b0; e.err = 1'b0; e.tag = t;
    case (o)
      3'd0: begin e.wd = {32'd0, r1[31:0]}; e.intf = 1'b1; end
      3'd1: e.wd = {32'hFFFF_FFFF, r1[31:0]};
      3'd2: e.wd = {32'hFFFF_FFFF, b[31], a[30:0]};
      3'd3: e.wd = {32'hFFFF_FFFF, ~b[31], a[30:0]};
      3'd4: e.wd = {32'hFFFF_FFFF, a[31] ^ b[31], a[30:0]};
`ifdef E203_FPU_FCLASS_EN
      3'd5: begin e.wd = fclass_ref(a); e.intf = 1'b1; end
`endif
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // One clock cycle: drive, check against the model, advance the model at the edge.
  task automatic cyc(input logic v, input logic [2:0] o, input logic [63:0] r1,
                     input logic [63:0] r2, input logic [2:0] t,
                     input logic ordy, input logic fl);
    logic exp_rdy;
    i_valid = v; op = o; rs1 = r1; rs2 = r2; itag = t; o_ready = ordy; flush = fl;
    #3;
    exp_rdy = (q.size() < DEPTH) && !fl;
    chk("i_ready", {63'd0, i_ready}, {63'd0, exp_rdy});
    chk("o_valid", {63'd0, o_valid}, {63'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("wdat", wdat, q[0].wd);
      chk("int",  {63'd0, wint}, {63'd0, q[0].intf});
      chk("itag", {61'd0, o_itag}, {61'd0, q[0].tag});
      chk("err",  {63'd0, err}, {63'd0, q[0].err});
    end
    @(posedge clk);
    if (ordy && q.size() != 0) void'(q.pop_front());
    if (fl) q.delete();
    else if (v && exp_rdy) q.push_back(ref_model(o, r1, r2, t));
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 3'd0, 64'd0, 64'd0, 3'd0, 1'b0, 1'b0);
  endtask

  // Check the head entry against a literal expected result.
  task automatic expect_head(input string tag, input logic [63:0] wd, input logic i, input logic e);
    chk({tag, "_valid"}, {63'd0, o_valid}, 64'd1);
    chk({tag, "_wdat"}, wdat, wd);
    chk({tag, "_int"}, {63'd0, wint}, {63'd0, i});
    chk({tag, "_err"}, {63'd0, err}, {63'd0, e});
  endtask

  function automatic logic [63:0] rnd_opnd();
    logic [31:0] lo;
    logic [31:0] hi;
    case ($urandom_range(0, 11))
      0: lo = 32'h0000_0000;
      1: lo = 32'h8000_0000;
      2: lo = 32'h7F80_0000;
      3: lo = 32'hFF80_0000;
      4: lo = 32'h7FC0_0000;
      5: lo = 32'h7F80_0001;
      6: lo = 32'h0000_0001;
      7: lo = 32'h8040_0000;
      default: lo = $urandom;
    endcase
    hi = ($urandom_range(0, 3) != 0) ? 32'hFFFF_FFFF : $urandom;
    return {hi, lo};
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; i_valid = 1'b0; op = 3'd0;
    rs1 = 64'd0; rs2 = 64'd0; itag = 3'd0; o_ready = 1'b0;
    #2;
    chk("rst_o_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_wdat", wdat, 64'd0);
    chk("rst_int_err_tag", {59'd0, wint, err, o_itag}, 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed test-plan results (each popped on the following cycle)
    cyc(1'b1, 3'd0, 64'h0000_0000_C049_0FDB, 64'd0, 3'd5, 1'b1, 1'b0);
    expect_head("fmv_x_w", 64'h0000_0000_C049_0FDB, 1'b1, 1'b0);
    chk("fmv_x_w_itag", {61'd0, o_itag}, 64'd5);
    cyc(1'b1, 3'd1, 64'h1234_5678_3F80_0000, 64'd0, 3'd1, 1'b1, 1'b0);
    expect_head("fmv_w_x", 64'hFFFF_FFFF_3F80_0000, 1'b0, 1'b0);
    cyc(1'b1, 3'd3, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_4000_0000, 3'd2, 1'b1, 1'b0);
    expect_head("fsgnjn_unbox", 64'hFFFF_FFFF_FFC0_0000, 1'b0, 1'b0);
    cyc(1'b1, 3'd4, 64'hFFFF_FFFF_BF80_0000, 64'hFFFF_FFFF_C000_0000, 3'd3, 1'b1, 1'b0);
    expect_head("fsgnjx", 64'hFFFF_FFFF_3F80_0000, 1'b0, 1'b0);
    cyc(1'b1, 3'd7, 64'hFFFF_FFFF_3F80_0000, 64'd0, 3'd4, 1'b1, 1'b0);
    expect_head("illegal7", 64'd0, 1'b0, 1'b1);
    cyc(1'b1, 3'd5, 64'hFFFF_FFFF_FF80_0000, 64'd0, 3'd6, 1'b1, 1'b0);
`ifdef E203_FPU_FCLASS_EN
    expect_head("fclass_ninf", 64'h001, 1'b1, 1'b0);
    cyc(1'b1, 3'd5, 64'hFFFF_FFFF_7FC0_0000, 64'd0, 3'd7, 1'b1, 1'b0);
    expect_head("fclass_qnan", 64'h200, 1'b1, 1'b0);
`else
    expect_head("fclass_off", 64'd0, 1'b0, 1'b1);
`endif
    idle();

    // Backpressure: two fit, the third waits until a pop has drained one
    cyc(1'b1, 3'd2, 64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_8000_0000, 3'd1, 1'b0, 1'b0);
    cyc(1'b1, 3'd1, 64'h0000_0000_0000_0011, 64'd0, 3'd2, 1'b0, 1'b0);
    cyc(1'b1, 3'd0, 64'h0000_0000_0000_0022, 64'd0, 3'd3, 1'b0, 1'b0);
    chk("full_not_accepted", q.size(), 64'd2);
    cyc(1'b1, 3'd0, 64'h0000_0000_0000_0022, 64'd0, 3'd3, 1'b1, 1'b0);
    cyc(1'b1, 3'd0, 64'h0000_0000_0000_0022, 64'd0, 3'd3, 1'b1, 1'b0);
    cyc(1'b0, 3'd0, 64'd0, 64'd0, 3'd0, 1'b1, 1'b0);
    cyc(1'b0, 3'd0, 64'd0, 64'd0, 3'd0, 1'b1, 1'b0);

    // Flush with two buffered and a request pending
    cyc(1'b1, 3'd1, 64'h0000_0000_0000_00AA, 64'd0, 3'd4, 1'b0, 1'b0);
    cyc(1'b1, 3'd1, 64'h0000_0000_0000_00BB, 64'd0, 3'd5, 1'b0, 1'b0);
    cyc(1'b1, 3'd1, 64'h0000_0000_0000_00CC, 64'd0, 3'd6, 1'b0, 1'b1);
    chk("flush_o_valid", {63'd0, o_valid}, 64'd0);
    idle();

    // Async reset mid-stream clears outputs immediately
    cyc(1'b1, 3'd1, 64'h0000_0000_0000_00DD, 64'd0, 3'd7, 1'b0, 1'b0);
    cyc(1'b1, 3'd0, 64'h0000_0000_0000_00EE, 64'd0, 3'd6, 1'b0, 1'b0);
    i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_o_valid", {63'd0, o_valid}, 64'd0);
    chk("arst_wdat", wdat, 64'd0);
    chk("arst_int_err_tag", {59'd0, wint, err, o_itag}, 64'd0);
    chk("arst_i_ready", {63'd0, i_ready}, 64'd1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    idle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      cyc(logic'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(),
          3'($urandom), logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
